// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming arithmetic-expression checker.
package expr_pkg;

    typedef enum logic [1:0] {
        S_OPND  = 2'd0,
        S_NUM   = 2'd1,
        S_CLOSE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_DIG = 3'd0,
        C_OP  = 3'd1,
        C_LP  = 3'd2,
        C_RP  = 3'd3,
        C_BAD = 3'd4
    } char_class_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_SUB  = 8'h2D;
    localparam logic [7:0] CH_LP   = 8'h28;
    localparam logic [7:0] CH_RP   = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier: maps one ASCII character onto the token classes the checker FSM uses.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_SUB = 1
) (
    input  logic [7:0]  in,
    output char_class_t char_cls
);

    always_comb begin
        char_cls = C_BAD;
        if (in >= CH_0 && in <= CH_9) begin
            char_cls = C_DIG;
        end else if (in == CH_PLUS || in == CH_MUL || (ALLOW_SUB != 0 && in == CH_SUB)) begin
            char_cls = C_OP;
        end else if (in == CH_LP) begin
            char_cls = C_LP;
        end else if (in == CH_RP) begin
            char_cls = C_RP;
        end
    end

endmodule

// File: rtl/expr_paren_checker.sv
// Streaming recognizer for +,*,- expressions with multi-digit numbers and bounded parenthesis nesting.
// in is consumed on every rising edge where in_valid is high; there is no backpressure path.
module expr_paren_checker
    import expr_pkg::*;
#(
    parameter int DEPTH_MAX   = 7,
    parameter int DEPTH_W     = 3,
    parameter int MULTI_DIGIT = 1,
    parameter int ALLOW_SUB   = 1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    localparam logic [DEPTH_W-1:0] DEPTH_TOP = DEPTH_W'(DEPTH_MAX);

    state_t             state, state_nxt;
    char_class_t        char_cls;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               out_nxt, err_nxt;

    expr_char_class #(
        .ALLOW_SUB(ALLOW_SUB)
    ) u_class (
        .in      (in),
        .char_cls(char_cls)
    );

    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        out_nxt   = out;
        err_nxt   = err;
        if (in_valid) begin
            case (state)
                S_OPND: begin
                    if (char_cls == C_DIG) begin
                        state_nxt = S_NUM;
                    end else if (char_cls == C_LP && depth != DEPTH_TOP) begin
                        depth_nxt = depth + DEPTH_W'(1);
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_NUM, S_CLOSE: begin
                    // A closing parenthesis is shared by both states; only S_NUM may extend a number.
                    if (char_cls == C_OP) begin
                        state_nxt = S_OPND;
                    end else if (char_cls == C_RP && depth != '0) begin
                        state_nxt = S_CLOSE;
                        depth_nxt = depth - DEPTH_W'(1);
                    end else if (char_cls == C_DIG && state == S_NUM && MULTI_DIGIT != 0) begin
                        state_nxt = S_NUM;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_ERR: state_nxt = S_ERR;
                default: begin
                    state_nxt = S_OPND;
                    depth_nxt = '0;
                end
            endcase
            out_nxt = (state_nxt == S_NUM || state_nxt == S_CLOSE) && depth_nxt == '0;
            err_nxt = (state_nxt == S_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= S_OPND;
            depth <= '0;
            out   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
            out   <= out_nxt;
            err   <= err_nxt;
        end
    end

endmodule
